mux21_rr_arbiter: RTL and testbench

- Two-requester round-robin arbiter that owns the select line of a shared 2:1 datapath mux.
- Grants one requester at a time and holds the grant for a whole packet, i.e. until the beat marked last has transferred.
- Forwards the granted requester's data onto a single valid/ready output channel.
- Sits in front of any shared downstream consumer fed by two producers.

---
 rtl/mux21_rr_arbiter_if.sv | 40 ++++
 rtl/mux21_rr_arbiter.sv | 85 ++++++++
 tb/tb_mux21_rr_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mux21_rr_arbiter_if.sv
// Bundle of the two requester channels and the shared output channel
// seen by the round-robin packet arbiter.
interface mux21_rr_arbiter_if #(
    parameter int WIDTH = 8
);
    logic             req0_valid;
    logic [WIDTH-1:0] req0_data;
    logic             req0_last;
    logic             req0_ready;

    logic             req1_valid;
    logic [WIDTH-1:0] req1_data;
    logic             req1_last;
    logic             req1_ready;

    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             out_ready;

    // Producer/consumer side: drives requests and downstream ready
    modport master (
        output req0_valid, req0_data, req0_last,
        input  req0_ready,
        output req1_valid, req1_data, req1_last,
        input  req1_ready,
        input  out_valid, out_data, out_last,
        output out_ready
    );

    // Arbiter side: takes requests, presents the muxed output beat
    modport slave (
        input  req0_valid, req0_data, req0_last,
        output req0_ready,
        input  req1_valid, req1_data, req1_last,
        output req1_ready,
        output out_valid, out_data, out_last,
        input  out_ready
    );
endinterface

// File: rtl/mux21_rr_arbiter.sv
// Two-requester round-robin packet arbiter driving the select line of a
// shared 2:1 mux. A grant is held from the first beat until the beat
// flagged last has transferred; ties go to the requester not served last.
module mux21_rr_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    mux21_rr_arbiter_if.slave     bus,
    output logic                  sel_o,
    output logic                  busy_o
);

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic             sel_q, sel_d;
    logic             prio_q, prio_d;

    logic             selValid;
    logic             selLast;
    logic [WIDTH-1:0] selData;

    // The datapath mux: follows the select register at all times
    always_comb begin
        selValid = sel_q ? bus.req1_valid : bus.req0_valid;
        selLast  = sel_q ? bus.req1_last  : bus.req0_last;
        selData  = sel_q ? bus.req1_data  : bus.req0_data;
    end

    assign bus.out_data = selData;
    assign sel_o        = sel_q;

    // Arbitration, packet locking and the gated handshake outputs
    always_comb begin
        state_d        = state_q;
        sel_d          = sel_q;
        prio_d         = prio_q;
        bus.out_valid  = 1'b0;
        bus.out_last   = 1'b0;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        busy_o         = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req0_valid || bus.req1_valid) begin
                    state_d = LOCK;
                    sel_d   = (bus.req0_valid && bus.req1_valid) ? prio_q : bus.req1_valid;
                end
            end
            LOCK: begin
                busy_o         = 1'b1;
                bus.out_valid  = selValid;
                bus.out_last   = selLast;
                bus.req0_ready = ~sel_q & bus.out_ready;
                bus.req1_ready =  sel_q & bus.out_ready;
                if (selValid && bus.out_ready && selLast) begin
                    state_d = IDLE;
                    prio_d  = ~sel_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, select and tie-break registers; reset abandons any packet
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            prio_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            prio_q  <= prio_d;
        end
    end

endmodule

// File: tb/tb_mux21_rr_arbiter.sv
// Self-checking bench for the round-robin packet arbiter. Producers are
// queues of {last,data} beats; the reference tracks which requester owns
// the output (or none) and who wins the next tie.
module tb_mux21_rr_arbiter;

    localparam int W = 8;

    logic clk = 1'b0;
    logic reset;
    logic sel;
    logic busy;

    always #5 clk = ~clk;

    mux21_rr_arbiter_if #(.WIDTH(W)) bus ();

    mux21_rr_arbiter #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus.slave),
        .sel_o  (sel),
        .busy_o (busy)
    );

    int checks = 0;
    int errors = 0;

    // Producer queues, valid suppression and downstream ready
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic       hold0, hold1, readyIn;

    // Reference: owner = -1 when nobody holds the output
    int   owner, favored, lastSel;
    logic v[2];
    logic [7:0] d[2];
    logic l[2];
    logic expValid, expLast, expR0, expR1, expBusy, expSel;
    logic [7:0] expData;
    logic [13:0] expVec;
    logic [13:0] actVec;
    logic [8:0] dutLog[$];
    logic [8:0] want[$];

    assign actVec = {bus.out_valid, bus.out_data, bus.out_last,
                     bus.req0_ready, bus.req1_ready, sel, busy};

    // Drive the requesters from their queues and work out what the output must be
    task automatic applyStimulus();
        v[0] = (q0.size() > 0) && !hold0;
        d[0] = (q0.size() > 0) ? q0[0][7:0] : 8'h00;
        l[0] = (q0.size() > 0) ? q0[0][8] : 1'b0;
        v[1] = (q1.size() > 0) && !hold1;
        d[1] = (q1.size() > 0) ? q1[0][7:0] : 8'h00;
        l[1] = (q1.size() > 0) ? q1[0][8] : 1'b0;
        bus.req0_valid = v[0]; bus.req0_data = d[0]; bus.req0_last = l[0];
        bus.req1_valid = v[1]; bus.req1_data = d[1]; bus.req1_last = l[1];
        bus.out_ready  = readyIn;
        expValid = 1'b0; expLast = 1'b0; expR0 = 1'b0; expR1 = 1'b0; expBusy = 1'b0;
        if (owner >= 0) begin
            expValid = v[owner];
            expLast  = l[owner];
            expBusy  = 1'b1;
            if (owner == 0) expR0 = readyIn;
            else            expR1 = readyIn;
        end
        expData = d[lastSel];
        expSel  = (lastSel == 1);
        expVec  = {expValid, expData, expLast, expR0, expR1, expSel, expBusy};
    endtask

    // Log what the DUT hands downstream, then step the reference over one edge
    task automatic advanceClock();
        if (bus.out_valid && bus.out_ready) dutLog.push_back({bus.out_last, bus.out_data});
        @(posedge clk);
        if (owner >= 0) begin
            if (v[owner] && readyIn) begin
                if (owner == 0) void'(q0.pop_front());
                else            void'(q1.pop_front());
                if (l[owner]) begin
                    favored = 1 - owner;
                    owner   = -1;
                end
            end
        end else if (v[0] || v[1]) begin
            owner   = (v[0] && v[1]) ? favored : (v[0] ? 0 : 1);
            lastSel = owner;
        end
        @(negedge clk);
    endtask

    task automatic resetDut();
        reset = 1'b1;
        q0.delete(); q1.delete();
        hold0 = 1'b0; hold1 = 1'b0; readyIn = 1'b0;
        owner = -1; favored = 0; lastSel = 0;
        applyStimulus();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        dutLog.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        q0.delete(); q1.delete();
        hold0 = 1'b0; hold1 = 1'b0; readyIn = 1'b0;
        owner = -1; favored = 0; lastSel = 0;
        applyStimulus();
        #1;
        checks++;
        if ({bus.out_valid, bus.out_last, bus.req0_ready, bus.req1_ready, sel, busy} !== 6'b0) begin
            errors++;
            $display("FAIL reset_state actual %b required 000000",
                     {bus.out_valid, bus.out_last, bus.req0_ready, bus.req1_ready, sel, busy});
        end
        @(negedge clk);
        reset = 1'b0;
        // Lock onto req1 mid-packet with downstream stalled
        q1.push_back(9'h0B0); q1.push_back(9'h0B1); q1.push_back(9'h1B2);
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            #1;
            checks++;
            if (actVec !== expVec) begin
                errors++;
                $display("FAIL reset_lock cyc %0d actual %h required %h", i, actVec, expVec);
            end
            advanceClock();
        end
        applyStimulus();
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.out_valid, bus.req0_ready, bus.req1_ready, busy, sel} !== 5'b0) begin
            errors++;
            $display("FAIL reset_async actual %b required 00000",
                     {bus.out_valid, bus.req0_ready, bus.req1_ready, busy, sel});
        end
        q0.delete(); q1.delete();
        owner = -1; favored = 0; lastSel = 0;
        q0.push_back(9'h11A);
        q1.push_back(9'h11B);
        readyIn = 1'b1;
        applyStimulus();
        @(negedge clk);
        reset = 1'b0;
        dutLog.delete();
        for (int i = 0; i < 6; i++) begin
            applyStimulus();
            #1;
            checks++;
            if (actVec !== expVec) begin
                errors++;
                $display("FAIL reset_regrant cyc %0d actual %h required %h", i, actVec, expVec);
            end
            advanceClock();
        end
        checks++;
        if (dutLog.size() != 2 || dutLog[0] !== 9'h11A || dutLog[1] !== 9'h11B) begin
            errors++;
            $display("FAIL reset_first_grant actual count %0d first %h required count 2 first 11a",
                     dutLog.size(), (dutLog.size() > 0) ? dutLog[0] : 9'h000);
        end
    endtask

    task automatic test_single_req0();
        resetDut();
        q0.push_back(9'h011); q0.push_back(9'h022); q0.push_back(9'h133);
        readyIn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            applyStimulus();
            #1;
            checks++;
            if (actVec !== expVec) begin
                errors++;
                $display("FAIL single_req0 cyc %0d actual %h required %h", i, actVec, expVec);
            end
            advanceClock();
        end
        want = '{9'h011, 9'h022, 9'h133};
        checks++;
        if (dutLog != want) begin
            errors++;
            $display("FAIL single_req0_seq actual count %0d required count 3", dutLog.size());
        end
        // req0 was served last, so a tie must now go to req1
        dutLog.delete();
        q0.push_back(9'h1C0);
        q1.push_back(9'h1D0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus();
            #1;
            checks++;
            if (actVec !== expVec) begin
                errors++;
                $display("FAIL prio_flip cyc %0d actual %h required %h", i, actVec, expVec);
            end
            advanceClock();
        end
        want = '{9'h1D0, 9'h1C0};
        checks++;
        if (dutLog != want) begin
            errors++;
            $display("FAIL prio_flip_seq actual first %h required 1d0",
                     (dutLog.size() > 0) ? dutLog[0] : 9'h000);
        end
    endtask

    task automatic test_back_to_back();
        resetDut();
        for (int p = 0; p < 2; p++) begin
            q0.push_back(9'h0A0); q0.push_back(9'h1A1);
            q1.push_back(9'h0B0); q1.push_back(9'h1B1);
        end
        readyIn = 1'b1;
        for (int i = 0; i < 16; i++) begin
            applyStimulus();
            #1;
            checks++;
            if (actVec !== expVec) begin
                errors++;
                $display("FAIL back_to_back cyc %0d actual %h required %h", i, actVec, expVec);
            end
            advanceClock();
        end
        want = '{9'h0A0, 9'h1A1, 9'h0B0, 9'h1B1, 9'h0A0, 9'h1A1, 9'h0B0, 9'h1B1};
        checks++;
        if (dutLog != want) begin
            errors++;
            $display("FAIL back_to_back_order actual count %0d required count 8", dutLog.size());
        end
    endtask

    task automatic test_backpressure();
        resetDut();
        q1.push_back(9'h0C0); q1.push_back(9'h0C1); q1.push_back(9'h0C2); q1.push_back(9'h1C3);
        for (int i = 0; i < 12; i++) begin
            readyIn = i[0];
            applyStimulus();
            #1;
            checks++;
            if (actVec !== expVec) begin
                errors++;
                $display("FAIL backpressure cyc %0d actual %h required %h", i, actVec, expVec);
            end
            advanceClock();
        end
        want = '{9'h0C0, 9'h0C1, 9'h0C2, 9'h1C3};
        checks++;
        if (dutLog != want) begin
            errors++;
            $display("FAIL backpressure_beats actual count %0d required count 4", dutLog.size());
        end
    endtask

    task automatic test_valid_drop();
        resetDut();
        q0.push_back(9'h0D0); q0.push_back(9'h0D1); q0.push_back(9'h1D2);
        q1.push_back(9'h0E0); q1.push_back(9'h1E1);
        readyIn = 1'b1;
        for (int i = 0; i < 16; i++) begin
            hold0 = (i >= 3 && i < 8);
            applyStimulus();
            #1;
            checks++;
            if (actVec !== expVec) begin
                errors++;
                $display("FAIL valid_drop cyc %0d actual %h required %h", i, actVec, expVec);
            end
            advanceClock();
        end
        hold0 = 1'b0;
        want = '{9'h0D0, 9'h0D1, 9'h1D2, 9'h0E0, 9'h1E1};
        checks++;
        if (dutLog != want) begin
            errors++;
            $display("FAIL valid_drop_order actual count %0d required count 5", dutLog.size());
        end
    endtask

    task automatic test_single_beat();
        resetDut();
        for (int k = 0; k < 4; k++) q1.push_back(9'h1F0 + 9'(k));
        readyIn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            applyStimulus();
            #1;
            checks++;
            if (actVec !== expVec) begin
                errors++;
                $display("FAIL single_beat cyc %0d actual %h required %h", i, actVec, expVec);
            end
            advanceClock();
        end
        want = '{9'h1F0, 9'h1F1, 9'h1F2, 9'h1F3};
        checks++;
        if (dutLog != want) begin
            errors++;
            $display("FAIL single_beat_seq actual count %0d required count 4", dutLog.size());
        end
    endtask

    task automatic test_random();
        int pushed;
        int len;
        int budget;
        resetDut();
        pushed = 0;
        for (int i = 0; i < 400; i++) begin
            if (q0.size() < 3 && $urandom_range(0, 2) == 0) begin
                len = $urandom_range(1, 4);
                for (int k = 0; k < len; k++) q0.push_back({(k == len - 1), 8'($urandom)});
                pushed += len;
            end
            if (q1.size() < 3 && $urandom_range(0, 2) == 0) begin
                len = $urandom_range(1, 4);
                for (int k = 0; k < len; k++) q1.push_back({(k == len - 1), 8'($urandom)});
                pushed += len;
            end
            hold0   = ($urandom_range(0, 5) == 0);
            hold1   = ($urandom_range(0, 5) == 0);
            readyIn = ($urandom_range(0, 3) != 0);
            applyStimulus();
            #1;
            checks++;
            if (actVec !== expVec) begin
                errors++;
                $display("FAIL random cyc %0d actual %h required %h", i, actVec, expVec);
            end
            advanceClock();
        end
        hold0 = 1'b0; hold1 = 1'b0; readyIn = 1'b1;
        budget = 0;
        while ((q0.size() > 0 || q1.size() > 0 || owner >= 0) && budget < 200) begin
            applyStimulus();
            #1;
            checks++;
            if (actVec !== expVec) begin
                errors++;
                $display("FAIL random_drain cyc %0d actual %h required %h", budget, actVec, expVec);
            end
            advanceClock();
            budget++;
        end
        checks++;
        if (dutLog.size() != pushed) begin
            errors++;
            $display("FAIL random_beat_count actual %0d required %0d", dutLog.size(), pushed);
        end
    endtask

    initial begin
        test_reset();
        test_single_req0();
        test_back_to_back();
        test_backpressure();
        test_valid_drop();
        test_single_beat();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
